// File: rtl/iq_symbol_if.sv
// Symbol stream interface for iq_symbol_mod: valid/ready handshake carrying signed I/Q pairs.
interface iq_symbol_if #(
    parameter int unsigned IQW = 8
);
    logic           s_valid;
    logic           s_ready;
    logic [IQW-1:0] s_i;
    logic [IQW-1:0] s_q;

    modport master (output s_valid, output s_i, output s_q, input s_ready);
    modport slave  (input s_valid, input s_i, input s_q, output s_ready);
endinterface

// File: rtl/iq_symbol_mod.sv
// Quadrature symbol modulator: FIFO-buffered I/Q symbols upconverted with an fs/4 LO to offset-binary DAC words.
// Optional constant-carrier test tone enabled by defining IQMOD_TESTTONE_EN (adds test_en port).
module iq_symbol_mod #(
    parameter int unsigned IQW       = 8,
    parameter int unsigned DACW      = 10,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SYMLEN    = 16,
    parameter int unsigned START_LVL = 2
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          locked,
`ifdef IQMOD_TESTTONE_EN
    input  logic                          test_en,
`endif
    iq_symbol_if.slave                    sif,
    output logic [DACW-1:0]               dacval,
    output logic                          active,
    output logic                          underrun,
    output logic [1:0]                    lo_phase,
    output logic [$clog2(DEPTH):0]        fifo_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(SYMLEN);
    localparam logic [IQW-1:0]  S_MIN   = {1'b1, {(IQW-1){1'b0}}};
    localparam logic [IQW-1:0]  S_MAX   = ~S_MIN;
    localparam logic [DACW-1:0] DAC_MID = {1'b1, {(DACW-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(SYMLEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_UNDER} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [IQW-1:0]   sym_i_q, sym_i_d, sym_q_q, sym_q_d;
    logic             tone_q, tone_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic [DACW-1:0]  dac_q, dac_d;
    logic             active_q, active_d, under_q, under_d;
    logic [2*IQW-1:0] mem_q [DEPTH];

    logic           lk, push, pop, flush, tone_go;
    logic [IQW-1:0] head_i, head_q, samp;

    function automatic logic [IQW-1:0] sat_neg(input logic [IQW-1:0] x);
        return (x == S_MIN) ? S_MAX : IQW'(~x + 1'b1);
    endfunction

    assign lk     = sync_q[1];
    assign push   = sif.s_valid & ready_q;
    assign head_i = mem_q[rd_ptr_q][2*IQW-1:IQW];
    assign head_q = mem_q[rd_ptr_q][IQW-1:0];

`ifdef IQMOD_TESTTONE_EN
    assign tone_go = lk & test_en;
`else
    assign tone_go = 1'b0;
`endif

    // Symbol sequencing FSM; symbol registers and LO phase are loaded with the values for the next output cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = 2'd0;
        sym_i_d = sym_i_q;
        sym_q_d = sym_q_q;
        tone_d  = tone_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tone_d = 1'b0;
                if (tone_go) begin
                    state_d = ST_RUN;
                    tone_d  = 1'b1;
                    cnt_d   = '0;
                    sym_i_d = S_MAX;
                    sym_q_d = '0;
                end else if (lk && (level_q >= LW'(START_LVL))) begin
                    state_d = ST_RUN;
                    pop     = 1'b1;
                    cnt_d   = '0;
                    sym_i_d = head_i;
                    sym_q_d = head_q;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_IDLE;
                    flush   = ~tone_q;
                    tone_d  = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d   = cnt_q + 1'b1;
                    phase_d = phase_q + 2'd1;
                end else if (tone_go) begin
                    cnt_d   = '0;
                    tone_d  = 1'b1;
                    sym_i_d = S_MAX;
                    sym_q_d = '0;
                end else if (tone_q) begin
                    state_d = ST_IDLE;
                    tone_d  = 1'b0;
                end else if (level_q != '0) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    sym_i_d = head_i;
                    sym_q_d = head_q;
                end else begin
                    state_d = ST_UNDER;
                end
            end
            ST_UNDER: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping; a lock-loss flush discards any same-cycle push.
    always_comb begin
        sync_d   = {sync_q[0], locked};
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        ready_d = (level_d < LW'(DEPTH));
    end

    // LO mixing (+I, +Q, -I, -Q) and offset-binary conversion.
    always_comb begin
        case (phase_d)
            2'd0:    samp = sym_i_d;
            2'd1:    samp = sym_q_d;
            2'd2:    samp = sat_neg(sym_i_d);
            default: samp = sat_neg(sym_q_d);
        endcase
        dac_d    = (state_d == ST_RUN) ? (DACW'({~samp[IQW-1], samp[IQW-2:0]}) << (DACW - IQW)) : DAC_MID;
        active_d = (state_d == ST_RUN);
        under_d  = (state_d == ST_UNDER);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            sym_i_q  <= '0;
            sym_q_q  <= '0;
            tone_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            dac_q    <= DAC_MID;
            active_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sym_i_q  <= sym_i_d;
            sym_q_q  <= sym_q_d;
            tone_q   <= tone_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            dac_q    <= dac_d;
            active_q <= active_d;
            under_q  <= under_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sif.s_i, sif.s_q};
    end

    assign sif.s_ready = ready_q;
    assign dacval      = dac_q;
    assign active      = active_q;
    assign underrun    = under_q;
    assign lo_phase    = phase_q;
    assign fifo_level  = level_q;
endmodule

// File: tb/tb_iq_symbol_mod.sv
// Directed self-checking bench for iq_symbol_mod at default parameters (IQW=8, DACW=10, DEPTH=4, SYMLEN=16).
module tb_iq_symbol_mod;
    logic       clk = 1'b0;
    logic       reset_;
    logic       locked;
    logic [9:0] dacval;
    logic       active, underrun;
    logic [1:0] lo_phase;
    logic [2:0] fifo_level;
`ifdef IQMOD_TESTTONE_EN
    logic       test_en;
`endif
    int checks = 0;
    int errors = 0;
    int qi[$], qq[$], pi[$], pq[$];

    iq_symbol_if #(.IQW(8)) sif ();

    iq_symbol_mod dut (
        .clk        (clk),
        .reset_     (reset_),
        .locked     (locked),
`ifdef IQMOD_TESTTONE_EN
        .test_en    (test_en),
`endif
        .sif        (sif),
        .dacval     (dacval),
        .active     (active),
        .underrun   (underrun),
        .lo_phase   (lo_phase),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offset-binary word for a signed 8-bit sample scaled to 10 bits.
    function automatic int exp_dac(input int v);
        return (v + 128) * 4;
    endfunction

    function automatic int lo_sample(input int i, input int q, input int ph);
        case (ph)
            0:       return i;
            1:       return q;
            2:       return (i == -128) ? 127 : -i;
            default: return (q == -128) ? 127 : -q;
        endcase
    endfunction

    task automatic push(input int i, input int q);
        sif.s_valid = 1'b1;
        sif.s_i     = 8'(i);
        sif.s_q     = 8'(q);
        qi.push_back(i);
        qq.push_back(q);
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_active(input string tag);
        int n = 0;
        while (active !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(active), 1);
    endtask

    // Feeds pending symbols whenever the FIFO has room.
    task automatic feed();
        sif.s_valid = 1'b0;
        if (pi.size() > 0 && sif.s_ready === 1'b1) begin
            sif.s_valid = 1'b1;
            sif.s_i     = 8'(pi[0]);
            sif.s_q     = 8'(pq[0]);
            qi.push_back(pi.pop_front());
            qq.push_back(pq.pop_front());
        end
    endtask

    task automatic run_check(input int nsym, input string tag);
        int i, q;
        for (int s = 0; s < nsym; s++) begin
            i = (qi.size() > 0) ? qi.pop_front() : 0;
            q = (qq.size() > 0) ? qq.pop_front() : 0;
            for (int c = 0; c < 16; c++) begin
                chk({tag, "_dac"}, 32'(dacval), 32'(exp_dac(lo_sample(i, q, c % 4))));
                chk({tag, "_phase"}, 32'(lo_phase), 32'(c % 4));
                chk({tag, "_active"}, 32'(active), 1);
                chk({tag, "_underrun"}, 32'(underrun), 0);
                feed();
                @(negedge clk);
            end
        end
        sif.s_valid = 1'b0;
        chk({tag, "_upulse"}, 32'(underrun), 1);
        chk({tag, "_udac"}, 32'(dacval), 512);
        chk({tag, "_uactive"}, 32'(active), 0);
        @(negedge clk);
        chk({tag, "_upulse_end"}, 32'(underrun), 0);
        chk({tag, "_idle_phase"}, 32'(lo_phase), 0);
    endtask

    initial begin
        reset_      = 1'b0;
        locked      = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_i     = '0;
        sif.s_q     = '0;
`ifdef IQMOD_TESTTONE_EN
        test_en     = 1'b0;
`endif
        #12;
        chk("rst_dac", 32'(dacval), 512);
        chk("rst_active", 32'(active), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_phase", 32'(lo_phase), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(sif.s_ready), 1);
        @(negedge clk);
        reset_ = 1'b1;
        locked = 1'b1;

        // Two symbols, then underrun.
        push(100, -50);
        push(-128, 127);
        wait_active("t1_start");
        run_check(2, "t1");

        // Fill while unlocked.
        locked = 1'b0;
        repeat (3) @(negedge clk);
        push(10, 20);
        push(30, 40);
        push(50, 60);
        push(70, 80);
        chk("t2_ready_full", 32'(sif.s_ready), 0);
        chk("t2_level_full", 32'(fifo_level), 4);
        sif.s_valid = 1'b1;
        sif.s_i     = 8'(99);
        sif.s_q     = 8'(99);
        @(negedge clk);
        sif.s_valid = 1'b0;
        chk("t2_level_hold", 32'(fifo_level), 4);
        chk("t2_dac_idle", 32'(dacval), 512);
        chk("t2_active_idle", 32'(active), 0);
        locked = 1'b1;
        @(negedge clk);
        chk("t2_lat1", 32'(active), 0);
        @(negedge clk);
        chk("t2_lat2", 32'(active), 0);
        @(negedge clk);
        chk("t2_lat3", 32'(active), 1);
        chk("t2_level_run", 32'(fifo_level), 3);

        // Continuous stream of six symbols, two fed while running.
        pi = '{-1, 64};
        pq = '{1, -64};
        run_check(6, "t3");
        chk("t3_level_end", 32'(fifo_level), 0);

        // Lock loss mid-symbol.
        push(5, -5);
        push(6, 6);
        wait_active("t4_start");
        chk("t4_first_dac", 32'(dacval), 532);
        repeat (5) @(negedge clk);
        chk("t4_level_pre", 32'(fifo_level), 1);
        locked = 1'b0;
        @(negedge clk);
        chk("t4_still1", 32'(active), 1);
        @(negedge clk);
        chk("t4_still2", 32'(active), 1);
        @(negedge clk);
        chk("t4_active", 32'(active), 0);
        chk("t4_dac", 32'(dacval), 512);
        chk("t4_level", 32'(fifo_level), 0);
        chk("t4_underrun", 32'(underrun), 0);
        @(negedge clk);
        chk("t4_underrun2", 32'(underrun), 0);
        qi.delete();
        qq.delete();

        // Asynchronous reset mid-symbol.
        locked = 1'b1;
        repeat (3) @(negedge clk);
        push(-64, 32);
        push(7, 7);
        wait_active("t5_start");
        chk("t5_first_dac", 32'(dacval), 256);
        repeat (3) @(negedge clk);
        reset_ = 1'b0;
        #1;
        chk("t5_dac", 32'(dacval), 512);
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_active", 32'(active), 0);
        chk("t5_phase", 32'(lo_phase), 0);
        chk("t5_ready", 32'(sif.s_ready), 1);
        #3;
        reset_ = 1'b1;
        @(negedge clk);
        qi.delete();
        qq.delete();
        push(20, -20);
        push(-20, 20);
        wait_active("t5_restart");
        run_check(2, "t5");

`ifdef IQMOD_TESTTONE_EN
        // Test tone ignores the FIFO.
        push(9, 9);
        chk("t6_level_pre", 32'(fifo_level), 1);
        test_en = 1'b1;
        wait_active("t6_start");
        for (int c = 0; c < 8; c++) begin
            chk("t6_dac", 32'(dacval), (c % 4 == 0) ? 1020 : (c % 4 == 2) ? 4 : 512);
            chk("t6_level", 32'(fifo_level), 1);
            @(negedge clk);
        end
        test_en = 1'b0;
        for (int n = 0; n < 20 && active === 1'b1; n++) begin
            chk("t6_underrun", 32'(underrun), 0);
            @(negedge clk);
        end
        chk("t6_stop", 32'(active), 0);
        chk("t6_level_post", 32'(fifo_level), 1);
        chk("t6_underrun_post", 32'(underrun), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
